// File: rtl/prio_encoder_rr_pkg.sv
// prio_pkg: shared constants and helpers for the registered round-robin
// priority encoder.
//   idx_width(n) : index width for an n-input encoder
//   MODE_FIXED   : rr_mode value for fixed priority (highest index wins)
//   MODE_RR      : rr_mode value for rotating round-robin priority
package prio_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Index width for n request lines. Kept at >= 1 so degenerate
   // parameterisations still elaborate.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prio_encoder_rr_pick.sv
// prio_pick: combinational highest-set-bit finder.
//   vec   : input bit vector
//   idx   : index of the highest set bit of vec (0 when vec is empty)
//   found : vec has at least one bit set
module prio_pick
   import prio_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0]              vec,
   output logic [idx_width(N)-1:0]   idx,
   output logic                      found
);

   localparam int unsigned W = idx_width(N);

   // Ascending scan; a later (higher) set bit overwrites an earlier one.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (vec[i]) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered priority encoder with sticky pending bits and
// runtime-selectable fixed / round-robin priority.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   req       : request lines; each high bit sets its pending bit
//   rr_mode   : MODE_FIXED = highest index wins, MODE_RR = rotating priority
//   out_valid : out_idx holds a granted index
//   out_idx   : granted request index
//   out_ready : consumer accepts out_idx when out_valid && out_ready
//   pend_any  : registered OR of the pending register
module prio_encoder_rr
   import prio_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N-1:0]              req,
   input  logic                      rr_mode,
   output logic                      out_valid,
   output logic [idx_width(N)-1:0]   out_idx,
   input  logic                      out_ready,
   output logic                      pend_any
);

   localparam int unsigned W = idx_width(N);

   logic [N-1:0] pending;
   logic [W-1:0] ptr;

   logic [N-1:0] rr_mask;
   logic [N-1:0] masked_pend;
   logic [W-1:0] m_idx;
   logic         m_found;
   logic [W-1:0] u_idx;
   logic         u_found;

   logic [W-1:0] sel_idx;
   logic         load;
   logic [N-1:0] clr_mask;
   logic [N-1:0] pending_next;
   logic [W-1:0] ptr_next;

   // Round-robin window: bits at or below the pointer.
   always_comb begin
      rr_mask = '0;
      for (int i = 0; i < int'(N); i++) begin
         rr_mask[i] = (W'(i) <= ptr);
      end
   end

   assign masked_pend = pending & rr_mask;

   prio_pick #(.N(N)) u_pick_masked (
      .vec   (masked_pend),
      .idx   (m_idx),
      .found (m_found)
   );

   prio_pick #(.N(N)) u_pick_full (
      .vec   (pending),
      .idx   (u_idx),
      .found (u_found)
   );

   // Selection, load decision and next pending/pointer values.
   // An empty RR window means the search wraps past 0 to N-1, which is
   // exactly the unmasked highest-bit pick.
   always_comb begin
      sel_idx      = u_idx;
      load         = 1'b0;
      clr_mask     = '0;
      pending_next = pending;
      ptr_next     = ptr;

      if ((rr_mode == MODE_RR) && m_found) begin
         sel_idx = m_idx;
      end

      load = (!out_valid || out_ready) && u_found;

      if (load) begin
         clr_mask = N'(1) << sel_idx;
         ptr_next = (sel_idx == '0) ? W'(N - 1) : (sel_idx - W'(1));
      end

      // Set wins over clear for a bit being granted this cycle.
      pending_next = (pending & ~clr_mask) | req;
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         ptr       <= W'(N - 1);
         out_valid <= 1'b0;
         out_idx   <= '0;
         pend_any  <= 1'b0;
      end else begin
         pending  <= pending_next;
         ptr      <= ptr_next;
         pend_any <= |pending_next;
         if (load) begin
            out_valid <= 1'b1;
            out_idx   <= sel_idx;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb_prio_encoder_rr: directed and randomized bench for prio_encoder_rr
// (N=8) against a search-based behavioural model.
module tb_prio_encoder_rr;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [N-1:0] req = '0;
   logic         rr_mode = 1'b0;
   logic         out_ready = 1'b1;
   logic         out_valid;
   logic [W-1:0] out_idx;
   logic         pend_any;

   int n_cmp = 0;
   int n_bad = 0;

   prio_encoder_rr #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .rr_mode   (rr_mode),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .out_ready (out_ready),
      .pend_any  (pend_any)
   );

   always #5 clk = ~clk;

   // Behavioural model state.
   bit         m_init  = 1'b0;
   bit [N-1:0] m_pend  = '0;
   bit         m_valid = 1'b0;
   int         m_idx   = 0;
   int         m_ptr   = N - 1;
   bit         m_any   = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Fixed: highest pending index. RR: walk downward from the pointer,
   // wrapping from 0 to N-1, and take the first pending bit.
   function automatic int model_pick(input bit [N-1:0] p, input bit rr, input int ptr);
      if (!rr) begin
         for (int i = N - 1; i >= 0; i--) if (p[i]) return i;
      end else begin
         for (int s = 0; s < N; s++) begin
            int j;
            j = (ptr - s + N) % N;
            if (p[j]) return j;
         end
      end
      return 0;
   endfunction

   always @(posedge clk) begin
      bit         ld;
      bit [N-1:0] clr;
      int         k;
      if (rst) begin
         m_init  = 1'b1;
         m_pend  = '0;
         m_valid = 1'b0;
         m_idx   = 0;
         m_ptr   = N - 1;
         m_any   = 1'b0;
      end else begin
         ld  = (!m_valid || out_ready) && (m_pend != 0);
         clr = '0;
         if (ld) begin
            k       = model_pick(m_pend, rr_mode, m_ptr);
            m_idx   = k;
            m_valid = 1'b1;
            clr[k]  = 1'b1;
            m_ptr   = (k == 0) ? N - 1 : k - 1;
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         m_pend = (m_pend & ~clr) | req;
         m_any  = (m_pend != 0);
      end
   end

   // Model-vs-DUT compare, every cycle after the first reset.
   always @(negedge clk) begin
      if (m_init) begin
         chk("out_valid", int'(out_valid), int'(m_valid));
         chk("out_idx",   int'(out_idx),   m_idx);
         chk("pend_any",  int'(pend_any),  int'(m_any));
      end
   end

   // One clock edge, then settle inputs/outputs away from the edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      int rr_seq[9];
      rr_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

      // Reset state.
      do_reset();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_idx",   int'(out_idx),   0);
      chk("rst_any",   int'(pend_any),  0);

      // Fixed priority, consumer always ready, req=0000_0101 for one cycle.
      rr_mode = 1'b0; out_ready = 1'b1; req = 8'b0000_0101;
      cyc();
      req = '0;
      chk("fx_lat_valid", int'(out_valid), 0);
      chk("fx_lat_any",   int'(pend_any),  1);
      cyc();
      chk("fx_g1_valid", int'(out_valid), 1);
      chk("fx_g1_idx",   int'(out_idx),   2);
      cyc();
      chk("fx_g2_idx", int'(out_idx),  0);
      chk("fx_g2_any", int'(pend_any), 0);
      cyc();
      chk("fx_idle_valid", int'(out_valid), 0);
      chk("fx_idle_idx",   int'(out_idx),   0);

      // Backpressure: grant held for 5 cycles, bit 0 stays pending.
      out_ready = 1'b0; req = 8'b0000_0101;
      cyc();
      req = '0;
      for (int c = 0; c < 5; c++) begin
         cyc();
         chk("bp_hold_idx",   int'(out_idx),   2);
         chk("bp_hold_valid", int'(out_valid), 1);
         chk("bp_hold_any",   int'(pend_any),  1);
      end
      out_ready = 1'b1;
      cyc();
      chk("bp_rel_idx", int'(out_idx), 0);
      cyc();
      chk("bp_drain_valid", int'(out_valid), 0);

      // Fixed starvation with all requests held.
      req = 8'hFF;
      cyc();
      for (int c = 0; c < 6; c++) begin
         cyc();
         chk("starve_idx", int'(out_idx), 7);
      end
      req = '0;
      repeat (10) cyc();

      // Round-robin from a fresh pointer.
      do_reset();
      rr_mode = 1'b1; req = 8'hFF;
      cyc();
      for (int c = 0; c < 9; c++) begin
         cyc();
         chk("rr_valid", int'(out_valid), 1);
         chk("rr_idx",   int'(out_idx),   rr_seq[c]);
      end
      req = '0;
      repeat (10) cyc();

      // Set wins over clear: req[7] again at the edge that loads index 7.
      do_reset();
      rr_mode = 1'b0; req = 8'h88;
      cyc();
      req = 8'h80;
      cyc();
      req = '0;
      chk("swc_first_idx", int'(out_idx), 7);
      cyc();
      chk("swc_again_idx", int'(out_idx), 7);
      cyc();
      chk("swc_next_idx", int'(out_idx), 3);
      repeat (3) cyc();

      // Reset while a grant is in flight and pending=3C.
      out_ready = 1'b0; req = 8'h7C;
      cyc();
      req = '0;
      cyc();
      chk("rmid_pre_valid", int'(out_valid), 1);
      chk("rmid_pre_idx",   int'(out_idx),   6);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rmid_valid", int'(out_valid), 0);
      chk("rmid_any",   int'(pend_any),  0);
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cyc();
         chk("rmid_quiet", int'(out_valid), 0);
      end

      // Randomized traffic, mode flips and backpressure, rare resets.
      for (int c = 0; c < 2000; c++) begin
         req       = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
         rst       = ($urandom_range(0, 199) == 0);
         cyc();
      end
      rst = 1'b0; req = '0; out_ready = 1'b1;
      repeat (12) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
